// File: rtl/lfsr_stream_checker.sv
// Receive-side integrity checker for the 20-bit trigger-gated LFSR counter
// (x^20 + x^13 + x^9 + x^5 + 1). It locks onto the observed word stream and
// tracks the generator state. Each sample must be either a hold or a single
// legal advance; anything else is flagged as a miss.
module lfsr_stream_checker #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [19:0]      lfsr_in,
    output logic             locked,
    output logic             adv_pulse,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [23:0]      adv_count,
    output logic [19:0]      expected
);

    typedef enum logic [0:0] {StSearch, StLocked} state_e;

    state_e             state_q, state_d;
    logic [19:0]        exp_q, exp_d;
    logic [3:0]         match_q, match_d;
    logic [3:0]         miss_q, miss_d;
    logic               adv_pulse_q, adv_pulse_d;
    logic               err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [23:0]        adv_cnt_q, adv_cnt_d;

    logic [19:0]        nxt_exp;
    logic               is_adv;
    logic               is_hold;
    logic [3:0]         match_inc;
    logic [3:0]         miss_inc;

    // One generator step: taps 15/11/7/0 feed the new MSB
    always_comb begin
        nxt_exp   = {exp_q[15] ^ exp_q[11] ^ exp_q[7] ^ exp_q[0], exp_q[19:1]};
        // The all-zero word is degenerate, so it never counts as a hold or an advance
        is_adv    = (exp_q != 20'd0) && (lfsr_in == nxt_exp);
        is_hold   = (exp_q != 20'd0) && (lfsr_in == exp_q);
        match_inc = match_q + 4'd1;
        miss_inc  = miss_q + 4'd1;
    end

    // Next-state: lock search, tracking, miss accounting
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        match_d     = match_q;
        miss_d      = miss_q;
        adv_pulse_d = 1'b0;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        adv_cnt_d   = adv_cnt_q;

        if (in_valid) begin
            unique case (state_q)
                StSearch: begin
                    exp_d = lfsr_in;
                    if (is_adv) begin
                        match_d = match_inc;
                        if (match_inc == 4'(LOCK_CNT)) begin
                            state_d = StLocked;
                            match_d = 4'd0;
                            miss_d  = 4'd0;
                        end
                    end else if (!is_hold) begin
                        match_d = 4'd0;
                    end
                end
                StLocked: begin
                    if (is_hold) begin
                        miss_d = 4'd0;
                    end else if (is_adv) begin
                        exp_d       = nxt_exp;
                        adv_pulse_d = 1'b1;
                        adv_cnt_d   = adv_cnt_q + 24'd1;
                        miss_d      = 4'd0;
                    end else begin
                        // Keep exp_q so that a lone corrupt word does not desync tracking
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != {ERR_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                        miss_d = miss_inc;
                        if (miss_inc == 4'(LOSS_CNT)) begin
                            state_d = StSearch;
                            exp_d   = lfsr_in;
                            match_d = 4'd0;
                            miss_d  = 4'd0;
                        end
                    end
                end
                default: state_d = StSearch;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StSearch;
            exp_q       <= 20'd0;
            match_q     <= 4'd0;
            miss_q      <= 4'd0;
            adv_pulse_q <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            adv_cnt_q   <= 24'd0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            adv_pulse_q <= adv_pulse_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            adv_cnt_q   <= adv_cnt_d;
        end
    end

    assign locked    = (state_q == StLocked);
    assign adv_pulse = adv_pulse_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;
    assign adv_count = adv_cnt_q;
    assign expected  = exp_q;

endmodule

// File: doc/lfsr_stream_checker.md
Name: lfsr_stream_checker

Overview:
- Receive-side companion to the 20-bit trigger-gated LFSR counter (X^20 + X^13 + X^9 + X^5 + 1).
- Samples the counter's 20-bit output word, locks onto the sequence, predicts each next state, and flags any word that is neither a hold nor a legal single-step advance.
- Used in the same clock domain to monitor counter integrity and to count advance events.

Parameters:
- LOCK_CNT, 4: consecutive legal advances seen in SEARCH before lock is declared (range 1..15).
- LOSS_CNT, 3: consecutive misses in LOCKED before lock is dropped (range 1..15).
- ERR_W, 16: width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  lfsr_in is sampled this cycle.
- lfsr_in  input  20  observed LFSR word.
- locked  output  1  checker is in LOCKED state.
- adv_pulse  output  1  one-cycle pulse: a legal advance was accepted while LOCKED.
- err_pulse  output  1  one-cycle pulse: a miss was detected while LOCKED.
- err_count  output  ERR_W  misses seen while LOCKED; saturates at all-ones.
- adv_count  output  24  advances accepted while LOCKED; wraps modulo 2^24.
- expected  output  20  current tracked state, exp_state.

Behaviour:
- Step function nxt(x) = {x[15]^x[11]^x[7]^x[0], x[19:1]}.
- The generator either holds (x -> x) or advances (x -> nxt(x)) each cycle. Both are legal.
- All outputs and internal registers are registered. Responses appear on the cycle after the sampling edge.
- Reset (rst=1 at a clock edge) overrides everything, including mid-lock:
  - state=SEARCH
  - exp_state=0, match_cnt=0, miss_cnt=0
  - locked=0, adv_pulse=0, err_pulse=0
  - err_count=0, adv_count=0
- When in_valid=0: no state change; both pulses are 0 the next cycle.
- SEARCH (locked=0), on in_valid=1:
  - If exp_state!=0 and lfsr_in==nxt(exp_state): match_cnt+1.
  - Else if exp_state!=0 and lfsr_in==exp_state: match_cnt unchanged (a hold proves nothing).
  - Else: match_cnt=0.
  - exp_state<=lfsr_in in all three cases.
  - When the incremented match_cnt equals LOCK_CNT: go to LOCKED, locked=1, miss_cnt=0.
  - No pulses and no counter updates in SEARCH.
- Zero word: the all-zero state is degenerate and never contributes to lock. A zero lfsr_in clears match_cnt on the following sample via the exp_state!=0 check.
- LOCKED, on in_valid=1:
  - Hold (lfsr_in==exp_state): miss_cnt=0; no pulse.
  - Advance (lfsr_in==nxt(exp_state)): exp_state<=nxt(exp_state), adv_pulse=1, adv_count+1, miss_cnt=0.
  - Otherwise (miss):
    - err_pulse=1; err_count+1, saturating.
    - exp_state is unchanged, so an isolated corrupt word does not desynchronise the checker.
    - miss_cnt+1.
    - If the incremented miss_cnt equals LOSS_CNT: go to SEARCH, locked=0, exp_state<=lfsr_in, match_cnt=0.
- Hold and advance are mutually exclusive for any nonzero exp_state. In LOCKED, exp_state is always nonzero.
- err_count and adv_count keep their values across lock loss; only rst clears them.

Test Plan:
- Lock acquisition: rst, then LOCK_CNT=4 and feed 00001, 80000, 40000, 20000, 10000 (in_valid=1, hex) -> locked=1 on the cycle after 10000 is sampled; expected=10000; no pulses; err_count=0.
- Holds and advance: after lock, feed 10000 x3 then 08000, then 84000 -> no pulses during the holds; adv_pulse on 08000 and on 84000; adv_count=2; expected=84000.
- Single glitch: after lock at 10000, feed 08001 then 08000 -> err_pulse for one cycle, err_count=1, locked stays 1; then adv_pulse, expected=08000.
- Lock loss: with LOSS_CNT=3 and lock at 10000, feed FFFFF, 12345, 00000 -> three err_pulses; err_count=3; locked=0 after the third sample; expected=00000. A following 00001, 80000... sequence relocks after 4 advances.
- Zero and in_valid gaps: from rst, feed 00000 x10, then 00001, 80000 with in_valid toggling 1/0 -> locked stays 0; state changes only on in_valid=1 samples.
- Reset mid-lock: assert rst for one cycle while locked with err_count=2 and adv_count=5 -> next cycle all outputs are 0, and the checker is back in SEARCH.
